// File: rtl/model_share_arbiter_if.sv
// Requester, response and model-side signal bundle for model_share_arbiter.
// The slave modport is the arbiter's view; master is the surrounding netlist/requesters.
interface model_share_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 5
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_i0;
  logic [NREQ*WIDTH-1:0] req_i1;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_o0;
  logic [WIDTH-1:0]      rsp_o1;
  logic [WIDTH-1:0]      m_i0;
  logic [WIDTH-1:0]      m_i1;
  logic [WIDTH-1:0]      m_o0;
  logic [WIDTH-1:0]      m_o1;
  logic                  busy;

  modport slave (
    input  req_valid, req_i0, req_i1, rsp_ready, m_o0, m_o1,
    output req_ready, rsp_valid, rsp_o0, rsp_o1, m_i0, m_i1, busy
  );

  modport master (
    output req_valid, req_i0, req_i1, rsp_ready, m_o0, m_o1,
    input  req_ready, rsp_valid, rsp_o0, rsp_o1, m_i0, m_i1, busy
  );
endinterface

// File: rtl/model_share_arbiter.sv
// Round-robin sharing of one two-port model datapath among NREQ requesters,
// one transaction in flight, operands held for LATENCY cycles before capture.
module model_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  model_share_arbiter_if.slave bus
);
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW1 = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gnt;
  logic [PW-1:0]    w_win;
  logic             w_any;
  logic [PW:0]      w_sum;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_m_i0;
  logic [WIDTH-1:0] r_m_i1;
  logic [WIDTH-1:0] r_rsp_o0;
  logic [WIDTH-1:0] r_rsp_o1;
  logic [WIDTH-1:0] w_sel_i0;
  logic [WIDTH-1:0] w_sel_i1;
  logic [NREQ-1:0]  w_req_ready;
  logic [NREQ-1:0]  w_rsp_valid;

  // Scan ptr, ptr+1, ... with an explicit modulo-NREQ wrap so non-power-of-two NREQ works.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + PW1'(k);
      if (w_sum >= PW1'(NREQ)) begin
        w_sum = w_sum - PW1'(NREQ);
      end
      if (!w_any && bus.req_valid[w_sum[PW-1:0]]) begin
        w_win = w_sum[PW-1:0];
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_i0 = '0;
    w_sel_i1 = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == w_win) begin
        w_sel_i0 = bus.req_i0[k*WIDTH +: WIDTH];
        w_sel_i1 = bus.req_i1[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready[w_win] = 1'b1;
          w_state_nxt        = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_rsp_valid[r_gnt] = 1'b1;
        if (bus.rsp_ready[r_gnt]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_cnt    <= '0;
      r_m_i0   <= '0;
      r_m_i1   <= '0;
      r_rsp_o0 <= '0;
      r_rsp_o1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt  <= w_win;
            r_m_i0 <= w_sel_i0;
            r_m_i1 <= w_sel_i1;
            r_cnt  <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_o0 <= bus.m_o0;
            r_rsp_o1 <= bus.m_o1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[r_gnt]) begin
            r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset holds the FSM in IDLE, so req_ready must be masked explicitly during reset.
  assign bus.req_ready = rst ? '0 : w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_o0    = r_rsp_o0;
  assign bus.rsp_o1    = r_rsp_o1;
  assign bus.m_i0      = r_m_i0;
  assign bus.m_i1      = r_m_i1;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_model_share_arbiter.sv
// Randomized bench for model_share_arbiter against a transaction/cycle-count reference model.
module tb_model_share_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 5;
  localparam int unsigned LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  model_share_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  model_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit         m_idle = 1'b1;
  int         m_ptr  = 0;
  int         m_gnt  = 0;
  int         m_acc  = 0;
  logic [W-1:0] ei0 = '0, ei1 = '0, eo0 = '0, eo1 = '0;
  int         cyc    = 0;
  int         mode   = 0;
  bit         hold_rsp = 1'b0;
  int         last_acc = -1;
  int         grants[NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [W-1:0] f0(input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b + W'(1);
  endfunction

  function automatic logic [W-1:0] f1(input logic [W-1:0] a, input logic [W-1:0] b);
    return a ^ ~b;
  endfunction

  task automatic drive();
    logic [NREQ-1:0] rv, rr;
    case (mode)
      1: begin rv = '1; rr = '1; end
      2: begin
        rv = (($urandom % 3) == 0) ? NREQ'($urandom) : '0;
        rr = NREQ'($urandom) & NREQ'($urandom);
      end
      default: begin rv = NREQ'($urandom); rr = NREQ'($urandom); end
    endcase
    if (hold_rsp) rr = '0;
    bus.req_valid = rv;
    bus.rsp_ready = rr;
    bus.req_i0    = (NREQ*W)'({$urandom, $urandom});
    bus.req_i1    = (NREQ*W)'({$urandom, $urandom});
    // the stand-in model only produces its real result in the sampling cycle
    if (!m_idle && cyc == m_acc + int'(LAT)) begin
      bus.m_o0 = f0(ei0, ei1);
      bus.m_o1 = f1(ei0, ei1);
    end else begin
      bus.m_o0 = W'($urandom);
      bus.m_o1 = W'($urandom);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
    chk({tag, "_m_i0"},      32'(bus.m_i0), 0);
    chk({tag, "_m_i1"},      32'(bus.m_i1), 0);
    chk({tag, "_rsp_o0"},    32'(bus.rsp_o0), 0);
    chk({tag, "_rsp_o1"},    32'(bus.rsp_o1), 0);
  endtask

  task automatic model_step();
    logic [NREQ-1:0] e_rr, e_rv;
    bit e_busy;
    int w;
    e_rr = '0; e_rv = '0; w = -1;
    if (m_idle) begin
      e_busy = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
        int idx;
        idx = (m_ptr + k) % int'(NREQ);
        if (w < 0 && bus.req_valid[idx]) w = idx;
      end
      if (w >= 0) e_rr[w] = 1'b1;
    end else begin
      e_busy = 1'b1;
      if (cyc > m_acc + int'(LAT)) e_rv[m_gnt] = 1'b1;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(e_rr));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
    chk("busy",      32'(bus.busy), 32'(e_busy));
    chk("m_i0",      32'(bus.m_i0), 32'(ei0));
    chk("m_i1",      32'(bus.m_i1), 32'(ei1));
    chk("rsp_o0",    32'(bus.rsp_o0), 32'(eo0));
    chk("rsp_o1",    32'(bus.rsp_o1), 32'(eo1));
    if (mode == 1 && bus.req_ready != '0) begin
      if (last_acc >= 0) chk("spacing", 32'(cyc - last_acc), LAT + 2);
      last_acc = cyc;
    end
    if (m_idle) begin
      if (w >= 0) begin
        m_idle = 1'b0;
        m_acc  = cyc;
        m_gnt  = w;
        ei0    = bus.req_i0[w*W +: W];
        ei1    = bus.req_i1[w*W +: W];
        grants[w]++;
      end
    end else if (cyc == m_acc + int'(LAT)) begin
      eo0 = f0(ei0, ei1);
      eo1 = f1(ei0, ei1);
    end else if (cyc > m_acc + int'(LAT) && bus.rsp_ready[m_gnt]) begin
      m_idle = 1'b1;
      m_ptr  = (m_gnt + 1) % int'(NREQ);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    model_step();
  endtask

  task automatic hit_reset();
    int n;
    n = 0;
    hold_rsp = 1'b1;
    while (!(!m_idle && cyc >= m_acc + int'(LAT)) && n < 60) begin
      cycle();
      n++;
    end
    chk("rst_wait_resp", 32'(n < 60), 1);
    cycle();
    chk("rst_pre_rsp_valid", 32'(bus.rsp_valid), 32'(m_idle ? 0 : (1 << m_gnt)));
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b1;
    drive();
    bus.req_valid = '1;
    #1;
    check_zero("rst_mid");
    m_idle = 1'b1; m_ptr = 0; m_gnt = 0;
    ei0 = '0; ei1 = '0; eo0 = '0; eo1 = '0;
    @(negedge clk);
    check_zero("rst_hold");
    hold_rsp = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    drive();
    @(negedge clk);
    model_step();
  endtask

  initial begin
    int gmin, gmax;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_i0    = '0;
    bus.req_i1    = '0;
    bus.m_o0      = '0;
    bus.m_o1      = '0;
    foreach (grants[i]) grants[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '1;
    #1;
    check_zero("rst_init");
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    drive();
    @(negedge clk);
    model_step();

    mode = 0;
    repeat (400) cycle();
    hit_reset();

    mode = 1;
    last_acc = -1;
    foreach (grants[i]) grants[i] = 0;
    repeat (80) cycle();
    gmin = grants[0];
    gmax = grants[0];
    foreach (grants[i]) begin
      if (grants[i] < gmin) gmin = grants[i];
      if (grants[i] > gmax) gmax = grants[i];
    end
    chk("rotation_spread", 32'(gmax - gmin <= 1), 1);
    chk("rotation_min", 32'(gmin >= 4), 1);

    mode = 2;
    repeat (400) cycle();
    hit_reset();

    mode = 0;
    repeat (300) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
